bp_update_cp4: RTL

Direction-prediction control for the branch predictor: converts cache lookups from `bp_cache_cp4` into fetch-time predictions and resolve-time counter updates. It drives both cache read ports and the write port, and keeps branch and mispredict statistics. The block sits between the fetch/execute stages and the predictor cache.

---
 rtl/bp_update_cp4.sv | 119 +++++++++++
 1 files changed

// File: rtl/bp_update_cp4.sv
// ----------------------------------------------------------------------------
// bp_update_cp4
// Direction-prediction control sitting between fetch/execute and the
// predictor cache (bp_cache_cp4). Produces fetch-time taken/not-taken
// predictions from cache port 0, reads the old saturating counter of a
// resolved branch through cache port 1, and writes the updated counter back
// through the cache write port one cycle later. Also keeps branch and
// mispredict statistics.
//
// Ports
//   clk               clock
//   reset             synchronous, active-low reset (0 = reset)
//   guess_addr        fetch-time branch word address
//   guess_taken       predicted direction for guess_addr
//   check_valid       resolved-branch event this cycle
//   check_addr        resolved branch word address
//   check_taken       actual branch direction
//   check_pred        direction predicted earlier for this branch
//   ra0/dout0/hit0    cache read port 0 (fetch lookup)
//   ra1/dout1/hit1    cache read port 1 (resolve lookup)
//   wa/din/we         cache write port
//   branch_count      resolved branches since reset
//   mispredict_count  resolved branches whose prediction was wrong
// ----------------------------------------------------------------------------
module bp_update_cp4 #(
   parameter int AWIDTH = 30,
   parameter int DWIDTH = 2,
   parameter int CWIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] guess_addr,
   output logic              guess_taken,
   input  logic              check_valid,
   input  logic [AWIDTH-1:0] check_addr,
   input  logic              check_taken,
   input  logic              check_pred,
   output logic [AWIDTH-1:0] ra0,
   input  logic [DWIDTH-1:0] dout0,
   input  logic              hit0,
   output logic [AWIDTH-1:0] ra1,
   input  logic [DWIDTH-1:0] dout1,
   input  logic              hit1,
   output logic [AWIDTH-1:0] wa,
   output logic [DWIDTH-1:0] din,
   output logic              we,
   output logic [CWIDTH-1:0] branch_count,
   output logic [CWIDTH-1:0] mispredict_count
);

   localparam logic [DWIDTH-1:0] CNT_MAX   = '1;
   localparam logic [DWIDTH-1:0] CNT_ONE   = {{(DWIDTH-1){1'b0}}, 1'b1};
   // Fresh allocations start weakly biased toward the observed direction.
   localparam logic [DWIDTH-1:0] ALLOC_TKN = {1'b1, {(DWIDTH-1){1'b0}}};
   localparam logic [DWIDTH-1:0] ALLOC_NTK = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [CWIDTH-1:0] STAT_ONE  = {{(CWIDTH-1){1'b0}}, 1'b1};

   // Registered resolve event (captured in S1, consumed in S2).
   logic              s2_valid;
   logic [AWIDTH-1:0] s2_addr;
   logic              s2_taken;
   logic [DWIDTH-1:0] s2_cnt;
   logic              s2_hit;

   logic [DWIDTH-1:0] next_cnt;
   logic              fwd_check;
   logic              fwd_guess;
   logic [DWIDTH-1:0] old_cnt;
   logic              old_hit;

   assign ra0 = guess_addr;
   assign ra1 = check_addr;

   // New counter value for the event held in S2, with explicit saturation.
   always_comb begin
      next_cnt = s2_cnt;
      if (!s2_hit) begin
         next_cnt = s2_taken ? ALLOC_TKN : ALLOC_NTK;
      end else if (s2_taken) begin
         if (s2_cnt != CNT_MAX) next_cnt = s2_cnt + CNT_ONE;
      end else begin
         if (s2_cnt != '0) next_cnt = s2_cnt - CNT_ONE;
      end
   end

   assign we  = s2_valid;
   assign wa  = s2_addr;
   assign din = next_cnt;

   // The cache has not yet committed the S2 write, so a same-address check
   // must see the pending value instead of the stale dout1.
   assign fwd_check = s2_valid && (s2_addr == check_addr);
   assign old_cnt   = fwd_check ? next_cnt : dout1;
   assign old_hit   = fwd_check | hit1;

   // Fetch side likewise sees the pending write before the cache does.
   assign fwd_guess   = we && (wa == guess_addr);
   assign guess_taken = fwd_guess ? next_cnt[DWIDTH-1] : (hit0 & dout0[DWIDTH-1]);

   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_valid         <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         s2_valid <= check_valid;
         if (check_valid) begin
            s2_addr      <= check_addr;
            s2_taken     <= check_taken;
            s2_cnt       <= old_cnt;
            s2_hit       <= old_hit;
            branch_count <= branch_count + STAT_ONE;
            if (check_pred != check_taken)
               mispredict_count <= mispredict_count + STAT_ONE;
         end
      end
   end

endmodule
